data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_array.sv | 32 +++
 rtl/data_mem_unit.sv | 143 ++++++++++++++
 tb/tb_data_mem_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory unit: FSM states, access sizes
// and byte-lane decoding.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SIZE_1B = 2'd0,
      SIZE_2B = 2'd1,
      SIZE_4B = 2'd2,
      SIZE_8B = 2'd3
   } size_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         SIZE_1B: mask = 8'h01;
         SIZE_2B: mask = 8'h03;
         SIZE_4B: mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   function automatic logic [63:0] data_mask(input logic [1:0] size);
      logic [63:0] mask;
      logic [7:0]  lanes;
      lanes = lane_mask(size);
      for (int k = 0; k < 8; k++) begin
         mask[8*k +: 8] = {8{lanes[k]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-wide storage with an 8-lane write enable and an 8-byte little-endian
// read port; lane k addresses byte addr_i+k.
module dmem_array #(
   parameter int DEPTH_BYTES = 1024
) (
   input  logic                           clk_i,
   input  logic [7:0]                     we_i,
   input  logic [$clog2(DEPTH_BYTES)-1:0] addr_i,
   input  logic [63:0]                    wdata_i,
   output logic [63:0]                    rdata_o
);

   localparam int AW = $clog2(DEPTH_BYTES);

   // Contents are never reset; they power up as zero.
   logic [7:0]    mem_q [DEPTH_BYTES] = '{default: 8'h00};
   logic [AW-1:0] lane_idx [8];

   for (genvar k = 0; k < 8; k++) begin : g_lane
      assign lane_idx[k]        = addr_i + AW'(k);
      assign rdata_o[8*k +: 8]  = mem_q[lane_idx[k]];
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 8; k++) begin
         if (we_i[k]) begin
            mem_q[lane_idx[k]] <= wdata_i[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/data_mem_unit.sv
// Request/response byte-addressable memory with fixed access latency, range
// checking and optional alignment checking.
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2,
   parameter int ALIGN_CHECK = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_rdata_o,
   output logic        rsp_error_o
);

   localparam int         AW       = $clog2(DEPTH_BYTES);
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        rsp_valid_q;
   logic        rsp_error_q;
   logic [63:0] rsp_rdata_q;

   logic        accept;
   logic        commit;
   logic        use_live;
   logic        cmd_we;
   logic [1:0]  cmd_size;
   logic [63:0] cmd_addr;
   logic [63:0] cmd_wdata;
   logic [3:0]  cmd_bytes;
   logic [64:0] end_addr;
   logic        range_err;
   logic        align_err;
   logic        cmd_err;
   logic [7:0]  arr_we;
   logic [63:0] arr_rdata;
   logic [63:0] rsp_rdata_d;

   assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign commit      = ((state_q == ST_BUSY) && (cnt_q == 4'd0)) || ((LATENCY == 1) && accept);

   // With single-cycle latency the commit happens on the accept edge, so the
   // live request fields are used instead of the latched copy.
   assign use_live  = (state_q == ST_IDLE);
   assign cmd_we    = use_live ? req_we_i    : we_q;
   assign cmd_size  = use_live ? req_size_i  : size_q;
   assign cmd_addr  = use_live ? req_addr_i  : addr_q;
   assign cmd_wdata = use_live ? req_wdata_i : wdata_q;

   assign cmd_bytes = size_bytes(cmd_size);
   assign end_addr  = {1'b0, cmd_addr} + 65'(cmd_bytes);
   assign range_err = end_addr > 65'(DEPTH_BYTES);
   assign align_err = (ALIGN_CHECK != 0) && ((cmd_addr[3:0] & (cmd_bytes - 4'd1)) != 4'd0);
   assign cmd_err   = range_err || align_err;

   assign arr_we      = (commit && cmd_we && !cmd_err) ? lane_mask(cmd_size) : 8'h00;
   assign rsp_rdata_d = (cmd_err || cmd_we) ? 64'd0 : (arr_rdata & data_mask(cmd_size));

   dmem_array #(
      .DEPTH_BYTES(DEPTH_BYTES)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (arr_we),
      .addr_i  (cmd_addr[AW-1:0]),
      .wdata_i (cmd_wdata),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         size_q      <= 2'd0;
         addr_q      <= 64'd0;
         wdata_q     <= 64'd0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= 64'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  we_q    <= req_we_i;
                  size_q  <= req_size_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  cnt_q   <= CNT_INIT;
                  if (LATENCY == 1) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= cmd_err;
                     rsp_rdata_q <= rsp_rdata_d;
                  end else begin
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= cmd_err;
                  rsp_rdata_q <= rsp_rdata_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_error_q <= 1'b0;
                  rsp_rdata_q <= 64'd0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_error_o = rsp_error_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench: two units (alignment check off / on) share one stimulus
// stream; expected responses are queued at issue and checked by monitors.
module tb_data_mem_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_ready;

   logic        ready0, valid0, err0;
   logic [63:0] rdata0;
   logic        ready1, valid1, err1;
   logic [63:0] rdata1;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;
   logic pv0 = 1'b0;
   logic pv1 = 1'b0;

   data_mem_unit #(.DEPTH_BYTES(1024), .LATENCY(2), .ALIGN_CHECK(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready0),
      .req_we_i(req_we), .req_size_i(req_size), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(valid0), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rdata0), .rsp_error_o(err0)
   );

   data_mem_unit #(.DEPTH_BYTES(1024), .LATENCY(2), .ALIGN_CHECK(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
      .req_we_i(req_we), .req_size_i(req_size), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(valid1), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rdata1), .rsp_error_o(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid0 && !pv0) begin
            if (q0.size() == 0) chk("unexpected_rsp0", 64'd1, 64'd0);
            else chk("latency0", 64'(cyc - q0[0].acc), 64'd2);
         end
         if (valid0 && rsp_ready && q0.size() != 0) begin
            chk("rdata0", rdata0, q0[0].rdata);
            chk("error0", 64'(err0), 64'(q0[0].err));
            void'(q0.pop_front());
         end
      end
      pv0 = valid0;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (valid1 && !pv1) begin
            if (q1.size() == 0) chk("unexpected_rsp1", 64'd1, 64'd0);
            else chk("latency1", 64'(cyc - q1[0].acc), 64'd2);
         end
         if (valid1 && rsp_ready && q1.size() != 0) begin
            chk("rdata1", rdata1, q1[0].rdata);
            chk("error1", 64'(err1), 64'(q1[0].err));
            void'(q1.pop_front());
         end
      end
      pv1 = valid1;
   end

   // Returns just after the accepting edge; inputs are then scrambled so a
   // unit that fails to latch the request produces a wrong response.
   task automatic issue(input logic we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata, input bit push,
                        input logic [63:0] r0, input logic e0,
                        input logic [63:0] r1, input logic e1);
      int   n;
      exp_t item;
      @(negedge clk);
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      n = 0;
      while (!(ready0 && ready1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("accept_timeout", 64'd1, 64'd0);
      if (push) begin
         item.rdata = r0; item.err = e0; item.acc = cyc;
         q0.push_back(item);
         item.rdata = r1; item.err = e1;
         q1.push_back(item);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_size  = 2'd3;
      req_addr  = 64'hDEAD_BEEF_0000_0000;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("response_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'd0;
      req_addr  = 64'd0;
      req_wdata = 64'd0;
      rsp_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("reset_ready0", 64'(ready0), 64'd0);
      chk("reset_ready1", 64'(ready1), 64'd0);
      chk("reset_valid0", 64'(valid0), 64'd0);
      chk("reset_rdata0", rdata0, 64'd0);
      chk("reset_error0", 64'(err0), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready0", 64'(ready0), 64'd1);

      issue(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0);
      wait_idle();
      issue(1'b0, 2'd3, 64'h10, 64'd0, 1'b1, 64'h1122334455667788, 1'b0, 64'h1122334455667788, 1'b0);
      wait_idle();
      issue(1'b0, 2'd0, 64'h10, 64'd0, 1'b1, 64'h88, 1'b0, 64'h88, 1'b0);
      wait_idle();
      issue(1'b0, 2'd1, 64'h13, 64'd0, 1'b1, 64'h4455, 1'b0, 64'd0, 1'b1);
      wait_idle();
      issue(1'b0, 2'd3, 64'h3FC, 64'd0, 1'b1, 64'd0, 1'b1, 64'd0, 1'b1);
      wait_idle();
      issue(1'b1, 2'd3, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 64'd0, 1'b1);
      wait_idle();
      issue(1'b0, 2'd2, 64'h3FC, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0);
      wait_idle();
      issue(1'b0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 64'd0, 1'b1, 64'd0, 1'b1);
      wait_idle();
      issue(1'b1, 2'd1, 64'h40, 64'h1234_5678_9ABC_BEEF, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0);
      wait_idle();
      issue(1'b0, 2'd2, 64'h40, 64'd0, 1'b1, 64'hBEEF, 1'b0, 64'hBEEF, 1'b0);
      wait_idle();

      // Back-pressure: response must hold while the consumer stalls.
      rsp_ready = 1'b0;
      issue(1'b0, 2'd3, 64'h10, 64'd0, 1'b1, 64'h1122334455667788, 1'b0, 64'h1122334455667788, 1'b0);
      n = 0;
      while (!valid0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("hold_valid_timeout", 64'd1, 64'd0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 64'(valid0), 64'd1);
         chk("hold_rdata", rdata0, 64'h1122334455667788);
         chk("hold_error", 64'(err0), 64'd0);
         chk("hold_ready", 64'(ready0), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("consume_cycle_ready", 64'(ready0), 64'd0);
      @(negedge clk);
      chk("after_consume_ready", 64'(ready0), 64'd1);
      chk("after_consume_valid", 64'(valid0), 64'd0);
      wait_idle();

      // Reset during BUSY abandons the pending write.
      issue(1'b1, 2'd0, 64'h20, 64'hAA, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_busy_valid0", 64'(valid0), 64'd0);
      chk("rst_busy_ready0", 64'(ready0), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_ready0", 64'(ready0), 64'd1);
      chk("rst_release_valid0", 64'(valid0), 64'd0);
      issue(1'b0, 2'd0, 64'h20, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
